// File: rtl/burst_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : burst_mem_pkg
// Description : Shared types and constants for the 4-beat x 64-bit burst
//               memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
package burst_mem_pkg;

    localparam int BEAT_W     = 64;
    localparam int BEATS      = 4;
    localparam int LINE_W     = BEAT_W * BEATS;
    localparam int BEAT_IDX_W = 2;

    typedef logic [LINE_W-1:0] line_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        BURST = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage : burst_mem_pkg
`default_nettype wire

// File: rtl/burst_mem_array.sv
`default_nettype none
// ============================================================================
// Module      : burst_mem_array
// Description : Beat-granular 1R/1W line store with a registered read port.
// Revision    : 1.0 - initial release
// ============================================================================
module burst_mem_array
    import burst_mem_pkg::*;
#(
    parameter int DEPTH_LINES = 256,
    parameter int IDX_W       = $clog2(DEPTH_LINES)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [IDX_W-1:0]      i_line,
    input  logic [BEAT_IDX_W-1:0] i_wr_beat,
    input  logic [BEAT_IDX_W-1:0] i_rd_beat,
    input  logic                  i_we,
    input  logic                  i_re,
    input  logic [BEAT_W-1:0]     i_wdata,
    output logic [BEAT_W-1:0]     o_rdata
);

    logic [BEAT_W-1:0] r_mem [DEPTH_LINES*BEATS];
    logic [BEAT_W-1:0] r_rdata;

    // Storage is deliberately left without reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[{i_line, i_wr_beat}] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[{i_line, i_rd_beat}];
        end else begin
            r_rdata <= '0;
        end
    end

    assign o_rdata = r_rdata;

endmodule : burst_mem_array
`default_nettype wire

// File: rtl/burst_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : burst_mem_responder
// Description : Responder for the 4-beat pmem burst protocol with programmable
//               access latency, sticky protocol-error flag and line storage.
// Revision    : 1.0 - initial release
// ============================================================================
module burst_mem_responder
    import burst_mem_pkg::*;
#(
    parameter int LATENCY     = 4,
    parameter int DEPTH_LINES = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_mem_read,
    input  logic              i_mem_write,
    input  logic [31:0]       i_mem_addr,
    input  logic [BEAT_W-1:0] i_mem_wdata,
    output logic [BEAT_W-1:0] o_mem_rdata,
    output logic              o_mem_resp,
    output logic              o_busy,
    output logic              o_err
);

    localparam int         IDX_W      = $clog2(DEPTH_LINES);
    localparam logic [3:0] c_LAT_LOAD = 4'(LATENCY - 1);

    state_t                  r_state;
    state_t                  w_next;
    logic                    r_is_write;
    logic [IDX_W-1:0]        r_line;
    logic [3:0]              r_lat_cnt;
    logic [BEAT_IDX_W-1:0]   r_beat;
    logic                    r_resp;
    logic                    r_err;

    logic                    w_req_held;
    logic                    w_accept;
    logic                    w_conflict;
    logic                    w_abort;
    logic                    w_we;
    logic                    w_re;
    logic [BEAT_IDX_W-1:0]   w_rd_beat;
    logic                    w_unused_addr;

    assign w_unused_addr = ^{i_mem_addr[31:5+IDX_W], i_mem_addr[4:0]};

    // An op switch looks the same as a deassert: the latched op is no longer requested alone.
    assign w_req_held = r_is_write ? (i_mem_write & ~i_mem_read)
                                   : (i_mem_read & ~i_mem_write);

    always_comb begin
        w_next     = r_state;
        w_accept   = 1'b0;
        w_conflict = 1'b0;
        w_abort    = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_mem_read && i_mem_write) begin
                    w_conflict = 1'b1;
                end else if (i_mem_read || i_mem_write) begin
                    w_accept = 1'b1;
                    w_next   = WAIT;
                end
            end
            WAIT: begin
                if (!w_req_held) begin
                    w_abort = 1'b1;
                    w_next  = IDLE;
                end else if (r_lat_cnt == 4'd0) begin
                    w_next = BURST;
                end
            end
            BURST: begin
                if (!w_req_held) begin
                    w_abort = 1'b1;
                    w_next  = IDLE;
                end else if (r_beat == 2'd3) begin
                    w_next = DONE;
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_is_write <= 1'b0;
            r_line     <= '0;
            r_lat_cnt  <= '0;
            r_beat     <= '0;
            r_resp     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_next;
            r_resp  <= (w_next == BURST);
            r_err   <= r_err | w_conflict | w_abort;
            if (w_accept) begin
                r_is_write <= i_mem_write;
                r_line     <= i_mem_addr[5 +: IDX_W];
                r_lat_cnt  <= c_LAT_LOAD;
                r_beat     <= '0;
            end else begin
                if (r_state == WAIT && r_lat_cnt != 4'd0) begin
                    r_lat_cnt <= r_lat_cnt - 4'd1;
                end
                if (r_state == BURST && w_req_held) begin
                    r_beat <= r_beat + 2'd1;
                end
            end
        end
    end

    // Read data is fetched one edge early so it lines up with the registered mem_resp.
    assign w_rd_beat = (r_state == BURST) ? r_beat + 2'd1 : 2'd0;
    assign w_re      = (w_next == BURST) && !r_is_write;
    assign w_we      = (r_state == BURST) && w_req_held && r_is_write;

    burst_mem_array #(
        .DEPTH_LINES (DEPTH_LINES),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_line    (r_line),
        .i_wr_beat (r_beat),
        .i_rd_beat (w_rd_beat),
        .i_we      (w_we),
        .i_re      (w_re),
        .i_wdata   (i_mem_wdata),
        .o_rdata   (o_mem_rdata)
    );

    assign o_mem_resp = r_resp;
    assign o_busy     = (r_state != IDLE);
    assign o_err      = r_err;

endmodule : burst_mem_responder
`default_nettype wire

// File: tb/tb_burst_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_burst_mem_responder
// Description : Scoreboard bench for burst_mem_responder with a line-level
//               reference memory and cycle-accurate beat expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_burst_mem_responder;

    localparam int LAT   = 4;
    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_mem_read = 1'b0;
    logic        i_mem_write = 1'b0;
    logic [31:0] i_mem_addr = '0;
    logic [63:0] i_mem_wdata = '0;
    logic [63:0] o_mem_rdata;
    logic        o_mem_resp;
    logic        o_busy;
    logic        o_err;

    burst_mem_responder #(
        .LATENCY     (LAT),
        .DEPTH_LINES (DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_mem_read  (i_mem_read),
        .i_mem_write (i_mem_write),
        .i_mem_addr  (i_mem_addr),
        .i_mem_wdata (i_mem_wdata),
        .o_mem_rdata (o_mem_rdata),
        .o_mem_resp  (o_mem_resp),
        .o_busy      (o_busy),
        .o_err       (o_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        bit          rd;
        logic [63:0] data;
    } exp_t;

    exp_t        q[$];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    bit          mon_en = 1'b0;
    logic [63:0] mdl [DEPTH][4];
    bit          written [DEPTH];
    logic [63:0] wbuf [4];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Every presented beat must have been predicted, at the predicted cycle, with the predicted data.
    always @(negedge clk) begin
        if (mon_en) begin
            if (o_mem_resp === 1'b1) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_resp: got mem_resp=1 expected no beat (cycle %0d)", cyc);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("resp_cycle", 64'(cyc), 64'(e.cyc));
                    if (e.rd) chk("rdata", o_mem_rdata, e.data);
                end
            end else begin
                chk("rdata_idle_zero", o_mem_rdata, 64'd0);
            end
        end
    end

    // Caller sits at a negedge. abort_at/rst_at select the beat at which the burst is cut short (4/-1 = none).
    task automatic burst(input bit wr, input logic [31:0] addr, input int abort_at, input int rst_at);
        int idx;
        int first;
        int nb;
        int seen;
        int t;
        idx = int'((addr >> 5) % DEPTH);
        t = 0;
        while (o_busy !== 1'b0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("idle_before_request", {63'd0, o_busy}, 64'd0);
        first = cyc + 1 + LAT;
        nb = (abort_at < 4) ? abort_at + 1 : ((rst_at >= 0) ? rst_at + 1 : 4);
        for (int k = 0; k < nb; k++) begin
            exp_t e;
            e.cyc  = first + k;
            e.rd   = !wr;
            e.data = mdl[idx][k];
            q.push_back(e);
        end
        i_mem_addr  = addr;
        i_mem_read  = !wr;
        i_mem_write = wr;
        seen = 0;
        t = 0;
        while (1) begin
            @(negedge clk);
            t++;
            if (t > LAT + 10) begin
                chk("burst_timeout_beats_seen", 64'(seen), 64'(nb));
                i_mem_read  = 1'b0;
                i_mem_write = 1'b0;
                q.delete();
                return;
            end
            if (o_mem_resp === 1'b1) begin
                int k;
                k = seen;
                seen++;
                if (k == abort_at) begin
                    i_mem_read  = 1'b0;
                    i_mem_write = 1'b0;
                    @(negedge clk);
                    chk("abort_resp_low", {63'd0, o_mem_resp}, 64'd0);
                    chk("abort_busy_low", {63'd0, o_busy}, 64'd0);
                    chk("abort_err_set", {63'd0, o_err}, 64'd1);
                    return;
                end
                if (k == rst_at) begin
                    #2 rst_n = 1'b0;
                    #1;
                    chk("rst_resp_low", {63'd0, o_mem_resp}, 64'd0);
                    chk("rst_busy_low", {63'd0, o_busy}, 64'd0);
                    chk("rst_rdata_zero", o_mem_rdata, 64'd0);
                    i_mem_read  = 1'b0;
                    i_mem_write = 1'b0;
                    @(negedge clk);
                    @(negedge clk);
                    rst_n = 1'b1;
                    return;
                end
                if (wr) begin
                    i_mem_wdata = wbuf[k];
                    mdl[idx][k] = wbuf[k];
                    written[idx] = 1'b1;
                end
                if (k == 3) break;
            end
        end
        @(negedge clk);
        i_mem_read  = 1'b0;
        i_mem_write = 1'b0;
        chk("done_resp_low", {63'd0, o_mem_resp}, 64'd0);
        chk("done_busy_high", {63'd0, o_busy}, 64'd1);
        @(negedge clk);
        chk("idle_busy_low", {63'd0, o_busy}, 64'd0);
    endtask

    initial begin
        int pool [8];
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk("reset_resp", {63'd0, o_mem_resp}, 64'd0);
        chk("reset_busy", {63'd0, o_busy}, 64'd0);
        chk("reset_err", {63'd0, o_err}, 64'd0);
        chk("reset_rdata", o_mem_rdata, 64'd0);
        mon_en = 1'b1;
        @(negedge clk);

        wbuf[0] = 64'h1111_1111_1111_1111;
        wbuf[1] = 64'h2222_2222_2222_2222;
        wbuf[2] = 64'h3333_3333_3333_3333;
        wbuf[3] = 64'h4444_4444_4444_4444;
        burst(1'b1, 32'h0000_0100, 4, -1);
        burst(1'b0, 32'h0000_0100, 4, -1);
        chk("err_after_clean_bursts", {63'd0, o_err}, 64'd0);

        for (int k = 0; k < 4; k++) wbuf[k] = {$urandom(), $urandom()};
        burst(1'b1, 32'h0000_2000, 4, -1);
        burst(1'b0, 32'h0000_0000, 4, -1);

        for (int i = 0; i < 8; i++) pool[i] = $urandom_range(0, DEPTH - 1);
        for (int n = 0; n < 40; n++) begin
            int          idx;
            bit          wr;
            logic [31:0] addr;
            idx  = pool[$urandom_range(0, 7)];
            wr   = !written[idx] || ($urandom_range(0, 1) == 1);
            addr = ($urandom() & ~32'h0000_1FE0) | (32'(idx) << 5);
            for (int k = 0; k < 4; k++) wbuf[k] = {$urandom(), $urandom()};
            burst(wr, addr, 4, -1);
        end
        chk("err_after_random", {63'd0, o_err}, 64'd0);

        i_mem_read  = 1'b1;
        i_mem_write = 1'b1;
        repeat (20) @(negedge clk);
        chk("conflict_err", {63'd0, o_err}, 64'd1);
        chk("conflict_busy", {63'd0, o_busy}, 64'd0);
        i_mem_read  = 1'b0;
        i_mem_write = 1'b0;
        @(negedge clk);

        for (int k = 0; k < 4; k++) wbuf[k] = {$urandom(), $urandom()};
        burst(1'b1, 32'h0000_0100, 2, -1);
        burst(1'b0, 32'h0000_0100, 4, -1);
        burst(1'b0, 32'h0000_0100, 1, -1);

        burst(1'b0, 32'h0000_0100, 4, 1);
        chk("err_cleared_by_reset", {63'd0, o_err}, 64'd0);
        chk("queue_empty_after_reset", 64'(q.size()), 64'd0);
        burst(1'b0, 32'h0000_0100, 4, -1);
        chk("err_after_recovery", {63'd0, o_err}, 64'd0);

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", 64'(q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_burst_mem_responder
`default_nettype wire
